// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation core:
// host register select encodings and the control state enum.
package rsa_pkg;

    localparam logic [1:0] SEL_M = 2'd0;
    localparam logic [1:0] SEL_C = 2'd1;
    localparam logic [1:0] SEL_D = 2'd2;
    localparam logic [1:0] SEL_N = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EXP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// MSB-first interleaved modular multiplier: result = x*y mod n.
// The start cycle does the first bit; done pulses one cycle after the last bit.
module rsa_modmul #(
    parameter int KEY_W = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [KEY_W-1:0] x,
    input  logic [KEY_W-1:0] y,
    input  logic [KEY_W-1:0] n,
    output logic [KEY_W-1:0] result,
    output logic             done
);

    localparam int ACC_W = KEY_W + 2;
    localparam int IDX_W = $clog2(KEY_W);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_src;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] n_ext;
    logic [ACC_W-1:0] dbl;
    logic [ACC_W-1:0] dbl_red;
    logic [ACC_W-1:0] sum;
    logic [IDX_W-1:0] idx;
    logic             scan_bit;
    logic             running;

    // A start restarts from a zero accumulator on the operand's top bit.
    always_comb begin
        acc_src  = start ? '0 : acc;
        scan_bit = start ? x[KEY_W-1] : x[idx];
        n_ext    = {2'b00, n};
        dbl      = {acc_src[ACC_W-2:0], 1'b0};
        dbl_red  = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum      = scan_bit ? dbl_red + {2'b00, y} : dbl_red;
        acc_next = (sum >= n_ext) ? sum - n_ext : sum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            idx     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= acc_next;
                idx     <= IDX_W'(KEY_W - 2);
                running <= 1'b1;
            end else if (running) begin
                acc <= acc_next;
                if (idx == '0) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

    assign result = acc[KEY_W-1:0];

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA modular exponentiation core: host-accessible N/D/C/M registers and a
// fixed-latency right-to-left square-and-multiply engine.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter  int KEY_W  = 256,
    parameter  int BUS_W  = 8,
    localparam int ADDR_W = $clog2(KEY_W / BUS_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic              oe,
    input  logic              start,
    input  logic [1:0]        reg_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  data_i,
    output logic [BUS_W-1:0]  data_o,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(KEY_W);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(KEY_W - 1);

    state_t state;
    state_t next_state;

    logic [KEY_W-1:0] n_reg;
    logic [KEY_W-1:0] d_reg;
    logic [KEY_W-1:0] c_reg;
    logic [KEY_W-1:0] m_reg;
    logic [KEY_W-1:0] r_reg;
    logic [KEY_W-1:0] b_reg;
    logic [KEY_W-1:0] sel_reg;
    logic [KEY_W-1:0] mul_r_res;
    logic [KEY_W-1:0] mul_b_res;
    logic [IDX_W-1:0] bit_idx;
    logic             kick;
    logic             mul_r_done;
    logic             mul_b_done;
    logic             step_done;
    logic             last_step;
    logic             operands_bad;

    assign busy         = (state == CHECK) || (state == EXP);
    assign operands_bad = (n_reg < KEY_W'(2)) || (c_reg >= n_reg);
    assign step_done    = (state == EXP) && mul_r_done && mul_b_done;
    assign last_step    = (bit_idx == LAST_BIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CHECK;
            CHECK:   next_state = operands_bad ? DONE : EXP;
            EXP:     if (step_done && last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Host writes land on the same edge that samples start, so CHECK sees them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_reg <= '0;
            d_reg <= '0;
            c_reg <= '0;
        end else if (we && !busy) begin
            case (reg_sel)
                SEL_N:   n_reg[addr*BUS_W +: BUS_W] <= data_i;
                SEL_D:   d_reg[addr*BUS_W +: BUS_W] <= data_i;
                SEL_C:   c_reg[addr*BUS_W +: BUS_W] <= data_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (reg_sel)
            SEL_N:   sel_reg = n_reg;
            SEL_D:   sel_reg = d_reg;
            SEL_C:   sel_reg = c_reg;
            default: sel_reg = m_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_o <= '0;
        end else if (oe) begin
            data_o <= sel_reg[addr*BUS_W +: BUS_W];
        end else begin
            data_o <= '0;
        end
    end

    // R and B only change on handoff cycles, so the multipliers see stable operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg   <= '0;
            r_reg   <= '0;
            b_reg   <= '0;
            bit_idx <= '0;
            kick    <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                CHECK: begin
                    if (operands_bad) begin
                        m_reg <= '0;
                        err   <= 1'b1;
                    end else begin
                        r_reg   <= KEY_W'(1);
                        b_reg   <= c_reg;
                        bit_idx <= '0;
                        kick    <= 1'b1;
                    end
                end
                EXP: begin
                    kick <= 1'b0;
                    if (step_done) begin
                        if (d_reg[bit_idx]) r_reg <= mul_r_res;
                        b_reg <= mul_b_res;
                        if (last_step) begin
                            m_reg <= d_reg[bit_idx] ? mul_r_res : r_reg;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            kick    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    rsa_modmul #(.KEY_W(KEY_W)) u_mul_r (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (kick),
        .x       (r_reg),
        .y       (b_reg),
        .n       (n_reg),
        .result  (mul_r_res),
        .done    (mul_r_done)
    );

    rsa_modmul #(.KEY_W(KEY_W)) u_mul_b (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (kick),
        .x       (b_reg),
        .y       (b_reg),
        .n       (n_reg),
        .result  (mul_b_res),
        .done    (mul_b_done)
    );

endmodule
